// File: rtl/fetch_unit_2w.sv
// fetch_unit_2w: two-wide instruction fetch front end with a pair FIFO toward decode.
// Optional static JAL prediction is enabled by defining STATIC_JAL_PREDICT_EN.

module fetch_lane #(
  parameter int LANE = 0
) (
  input  logic [31:0] pc_base,
  output logic [31:0] pc
`ifdef STATIC_JAL_PREDICT_EN
  ,
  input  logic [31:0] instr,
  output logic        is_jal,
  output logic [31:0] target
`endif
);
  assign pc = pc_base + 32'(4 * LANE);

`ifdef STATIC_JAL_PREDICT_EN
  logic [31:0] imm;
  logic        unused_rd;

  // J-type immediate: imm[20|10:1|11|19:12], sign-extended, bit 0 zero
  assign imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign is_jal    = (instr[6:0] == 7'b1101111);
  assign target    = pc + imm;
  assign unused_rd = ^instr[11:7];
`endif
endmodule

module fetch_unit_2w #(
  parameter logic [31:0] P_RESET_PC = 32'h200,
  parameter int          P_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fakepc1,
  output logic [31:0] fakepc2,
  input  logic [31:0] fakeinstr1,
  input  logic [31:0] fakeinstr2,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dec_val,
  output logic [31:0] dec_pc0,
  output logic [31:0] dec_instr0,
  output logic [31:0] dec_pc1,
  output logic [31:0] dec_instr1,
  input  logic        dec_rdy
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;
  localparam int PTR_W     = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [VEC_W-1:0]                  pc;
    logic [NUM_LANES-1:0][VEC_W-1:0]   instr;
    logic [NUM_LANES-1:0]              mask;
  } fetch_ent_t;

  logic [VEC_W-1:0]                pc_q;
  logic [VEC_W-1:0]                pc_fetch_nxt;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_pc;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_instr;
  logic [NUM_LANES-1:0]            enq_mask;

  fetch_ent_t       fifo_q [P_DEPTH];
  fetch_ent_t       enq_ent;
  fetch_ent_t       head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             full, empty, enq, deq;
  logic             unused_lsb;

  assign lane_instr = {fakeinstr2, fakeinstr1};
  assign unused_lsb = ^redirect_pc[1:0];

`ifdef STATIC_JAL_PREDICT_EN
  logic [NUM_LANES-1:0]            lane_jal;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_tgt;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fetch_lane #(.LANE(l)) u_lane (
      .pc_base (pc_q),
      .pc      (lane_pc[l])
`ifdef STATIC_JAL_PREDICT_EN
      ,
      .instr   (lane_instr[l]),
      .is_jal  (lane_jal[l]),
      .target  (lane_tgt[l])
`endif
    );
  end

  assign fakepc1 = lane_pc[0];
  assign fakepc2 = lane_pc[1];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  assign full  = (cnt_q == CNT_W'(P_DEPTH));
  assign empty = (cnt_q == '0);
  assign enq   = !redirect_val && !full;
  assign deq   = !redirect_val && dec_rdy && !empty;

  always_comb begin
    enq_mask     = '1;
    pc_fetch_nxt = pc_q + 32'd8;
`ifdef STATIC_JAL_PREDICT_EN
    // A taken slot-0 JAL kills slot 1; a slot-1 JAL only steers the next PC
    if (lane_jal[0]) begin
      enq_mask     = 2'b01;
      pc_fetch_nxt = lane_tgt[0];
    end else if (lane_jal[1]) begin
      pc_fetch_nxt = lane_tgt[1];
    end
`endif
  end

  always_comb begin
    enq_ent       = '0;
    enq_ent.pc    = pc_q;
    enq_ent.instr = lane_instr;
    enq_ent.mask  = enq_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= P_RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (redirect_val) begin
      pc_q   <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) begin
        pc_q   <= pc_fetch_nxt;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Storage needs no reset: entries are only observed behind a nonzero count
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= enq_ent;
  end

  assign head       = fifo_q[rd_ptr];
  assign dec_val    = empty ? 2'b00 : head.mask;
  assign dec_pc0    = head.pc;
  assign dec_pc1    = head.pc + 32'd4;
  assign dec_instr0 = head.instr[0];
  assign dec_instr1 = head.instr[1];
endmodule

// File: tb/tb_fetch_unit_2w.sv
// Self-checking bench for fetch_unit_2w: directed scenarios then random traffic,
// all checked against a queue-based reference model of the fetch/decode contract.

module tb_fetch_unit_2w;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fakepc1, fakepc2, fakeinstr1, fakeinstr2;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_val;
  logic [31:0] dec_pc0, dec_instr0, dec_pc1, dec_instr1;
  logic        dec_rdy;

  int checks = 0;
  int errors = 0;

  logic [31:0] jal_addr = 32'h1;
  logic [31:0] jal_word = 32'hFC1FFF6F;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  mask;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  fetch_unit_2w #(.P_RESET_PC(32'h200), .P_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fakepc1      (fakepc1),
    .fakepc2      (fakepc2),
    .fakeinstr1   (fakeinstr1),
    .fakeinstr2   (fakeinstr2),
    .redirect_val (redirect_val),
    .redirect_pc  (redirect_pc),
    .dec_val      (dec_val),
    .dec_pc0      (dec_pc0),
    .dec_instr0   (dec_instr0),
    .dec_pc1      (dec_pc1),
    .dec_instr1   (dec_instr1),
    .dec_rdy      (dec_rdy)
  );

  always #5 clk = ~clk;

  // Instruction memory: address hash with an ALU opcode, plus one optional JAL slot
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    logic [31:0] h;
    if (a == jal_addr) return jal_word;
    h = (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    return {h[31:7], 7'h13};
  endfunction

  assign fakeinstr1 = mem_f(fakepc1);
  assign fakeinstr2 = mem_f(fakepc2);

  function automatic logic [31:0] jimm(input logic [31:0] w);
    logic signed [20:0] s;
    s = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return 32'(int'(s));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ev;
    ev = (mq.size() > 0) ? 32'(mq[0].mask) : 32'h0;
    chk("fakepc1", fakepc1, mpc);
    chk("fakepc2", fakepc2, mpc + 32'd4);
    chk("dec_val", 32'(dec_val), ev);
    if (mq.size() > 0) begin
      chk("dec_pc0", dec_pc0, mq[0].pc);
      chk("dec_pc1", dec_pc1, mq[0].pc + 32'd4);
      chk("dec_instr0", dec_instr0, mq[0].i0);
      chk("dec_instr1", dec_instr1, mq[0].i1);
    end
  endtask

  task automatic model_update(input logic rv, input logic [31:0] rp, input logic rdy);
    ent_t        e;
    logic [31:0] npc;
    bit          was_full;
    if (rv) begin
      mq.delete();
      mpc = {rp[31:2], 2'b00};
    end else begin
      was_full = (mq.size() == DEPTH);
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (!was_full) begin
        e.pc = mpc; e.i0 = mem_f(mpc); e.i1 = mem_f(mpc + 32'd4); e.mask = 2'b11;
        npc = mpc + 32'd8;
`ifdef STATIC_JAL_PREDICT_EN
        if (e.i0[6:0] == 7'h6F) begin
          e.mask = 2'b01;
          npc    = mpc + jimm(e.i0);
        end else if (e.i1[6:0] == 7'h6F) begin
          npc    = mpc + 32'd4 + jimm(e.i1);
        end
`endif
        mq.push_back(e);
        mpc = npc;
      end
    end
  endtask

  // One cycle: drive at negedge, check settled outputs, advance model past posedge
  task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
    redirect_val = rv; redirect_pc = rp; dec_rdy = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(rv, rp, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    mq.delete();
    mpc = 32'h200;
    chk("rst_fakepc1", fakepc1, 32'h200);
    chk("rst_fakepc2", fakepc2, 32'h204);
    chk("rst_dec_val", 32'(dec_val), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rp;
    reset = 1'b1; redirect_val = 1'b0; redirect_pc = '0; dec_rdy = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: first pair visible one cycle after fetch
    step(0, 0, 1);
    chk("t1_fakepc1", fakepc1, 32'h208);
    chk("t1_dec_val", 32'(dec_val), 32'h3);
    chk("t1_dec_pc0", dec_pc0, 32'h200);
    chk("t1_dec_pc1", dec_pc1, 32'h204);
    chk("t1_instr0", dec_instr0, mem_f(32'h200));
    chk("t1_instr1", dec_instr1, mem_f(32'h204));

    // 2: saturate at DEPTH, then drain in order
    do_reset();
    repeat (6) step(0, 0, 0);
    chk("t2_full_pc", fakepc1, 32'h220);
    chk("t2_head", dec_pc0, 32'h200);
    repeat (6) step(0, 0, 1);

    // 3: redirect flushes queued entries
    do_reset();
    repeat (3) step(0, 0, 0);
    step(1, 32'h1F8, 0);
    chk("t3_dec_val", 32'(dec_val), 32'h0);
    chk("t3_fakepc1", fakepc1, 32'h1F8);
    chk("t3_fakepc2", fakepc2, 32'h1FC);
    step(0, 0, 0);
    chk("t3_head", dec_pc0, 32'h1F8);

    // 4: redirect beats pop, low bits dropped, PC wraps
    step(0, 0, 0);
    step(1, 32'h206, 1);
    chk("t4_fakepc1", fakepc1, 32'h204);
    chk("t4_dec_val", 32'(dec_val), 32'h0);
    step(1, 32'hFFFF_FFF8, 0);
    step(0, 0, 0);
    chk("t4_wrap", fakepc1, 32'h0);
    step(1, 32'hFFFF_FFFC, 0);
    chk("t4_wrap2", fakepc2, 32'h0);
    step(0, 0, 1);

    // 5: JAL in slot 0, then in slot 1
    jal_addr = 32'h240;
    step(1, 32'h240, 0);
    step(0, 0, 0);
`ifdef STATIC_JAL_PREDICT_EN
    chk("t5_s0_pc", fakepc1, 32'h200);
    chk("t5_s0_mask", 32'(dec_val), 32'h1);
`else
    chk("t5_s0_pc", fakepc1, 32'h248);
    chk("t5_s0_mask", 32'(dec_val), 32'h3);
`endif
    jal_addr = 32'h304;
    step(1, 32'h300, 0);
    step(0, 0, 0);
`ifdef STATIC_JAL_PREDICT_EN
    chk("t5_s1_pc", fakepc1, 32'h2C4);
`else
    chk("t5_s1_pc", fakepc1, 32'h308);
`endif
    chk("t5_s1_mask", 32'(dec_val), 32'h3);
    jal_addr = 32'h1;
    step(1, 32'h400, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      step(($urandom_range(0, 15) == 0), rp, $urandom_range(0, 2) != 0);
    end

    // 6: reset mid-run wins over redirect
    repeat (3) step(0, 0, 0);
    redirect_val = 1'b1; redirect_pc = 32'h800;
    reset = 1'b1;
    #1;
    mq.delete();
    mpc = 32'h200;
    chk("t6_dec_val", 32'(dec_val), 32'h0);
    chk("t6_fakepc1", fakepc1, 32'h200);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 1);
    chk("t6_restart", dec_pc0, 32'h200);
    repeat (4) step(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
